// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: ALU function codes, opcode class
// and forwarding-select encodings, plus default datapath widths.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_NOR   = 4'd5,
    ALU_SLT   = 4'd6,
    ALU_SLL   = 4'd7,
    ALU_SRL   = 4'd8,
    ALU_SRA   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  localparam logic [1:0] MEM_CLASS = 2'b01;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

endpackage

// File: rtl/execute_stage_alu.sv
// Combinational ALU: selects one of the arithmetic/logic/shift functions and
// flags signed overflow for ADD/SUB. Codes 10-15 all pass operand B through.
module alu
  import mips_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   func,
  output logic [W-1:0] result,
  output logic         ovf
);

  localparam int SH_W = $clog2(W);

  logic [SH_W-1:0] shamt;
  logic [W-1:0]    sum;
  logic [W-1:0]    diff;

  assign shamt = b[SH_W-1:0];
  assign sum   = a + b;
  assign diff  = a - b;

  always_comb begin
    result = b;
    ovf    = 1'b0;
    case (func)
      ALU_ADD: begin
        result = sum;
        ovf    = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
      ALU_SUB: begin
        result = diff;
        ovf    = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_NOR: result = ~(a | b);
      ALU_SLT: result = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLL: result = a << shamt;
      ALU_SRL: result = a >> shamt;
      ALU_SRA: result = $unsigned($signed(a) >>> shamt);
      default: result = b;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// EX stage: operand forwarding, ALU / address generation, and the EX/MEM
// pipeline register, whose ALU result also feeds back as forwarding source 01.
module execute_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int REG_AW = mips_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_ex,
  input  logic [5:0]        op_dec,
  input  logic [15:0]       imm,
  input  logic              imm_sel,
  input  logic [1:0]        mux_sel_A,
  input  logic [1:0]        mux_sel_B,
  input  logic [REG_AW-1:0] RW_ex,
  input  logic              mem_en_ex,
  input  logic              mem_rw_ex,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] alu_out_mem,
  output logic [DATA_W-1:0] store_data_mem,
  output logic [REG_AW-1:0] RW_dm,
  output logic              mem_en_mem,
  output logic              mem_rw_mem,
  output logic              reg_wr_mem,
  output logic              zero_mem,
  output logic              ovf_mem
);

  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] alu_b;
  logic [3:0]        alu_func;
  logic [DATA_W-1:0] alu_result;
  logic              alu_ovf;
  logic              mem_class;
  logic              reg_wr_next;

  logic [DATA_W-1:0] alu_out_reg;
  logic [DATA_W-1:0] store_data_reg;
  logic [REG_AW-1:0] rw_reg;
  logic              mem_en_reg;
  logic              mem_rw_reg;
  logic              reg_wr_reg;
  logic              zero_reg;
  logic              ovf_reg;

  // Source 01 is the registered EX/MEM result, so a held value stays visible
  // to the next instruction while stalled.
  always_comb begin
    case (mux_sel_A)
      FWD_EXMEM: fwd_a = alu_out_reg;
      FWD_MEMWB: fwd_a = wb_data;
      default:   fwd_a = rs_data;
    endcase
    case (mux_sel_B)
      FWD_EXMEM: fwd_b = alu_out_reg;
      FWD_MEMWB: fwd_b = wb_data;
      default:   fwd_b = rt_data;
    endcase
  end

  assign imm_ext   = {{(DATA_W-16){imm[15]}}, imm};
  assign mem_class = (op_dec[5:4] == MEM_CLASS);
  assign alu_b     = (imm_sel || mem_en_ex || mem_class) ? imm_ext : fwd_b;
  assign alu_func  = mem_class ? ALU_ADD : op_dec[3:0];

  alu #(.W(DATA_W)) u_alu (
    .a      (fwd_a),
    .b      (alu_b),
    .func   (alu_func),
    .result (alu_result),
    .ovf    (alu_ovf)
  );

  assign reg_wr_next = valid_ex & ~(mem_en_ex & mem_rw_ex) & (RW_ex != '0);

  // Priority: reset, then flush (beats stall), then stall, then bubble/load.
  always_ff @(posedge clk) begin
    if (reset || flush || (!stall && !valid_ex)) begin
      alu_out_reg    <= '0;
      store_data_reg <= '0;
      rw_reg         <= '0;
      mem_en_reg     <= 1'b0;
      mem_rw_reg     <= 1'b0;
      reg_wr_reg     <= 1'b0;
      zero_reg       <= 1'b0;
      ovf_reg        <= 1'b0;
    end else if (!stall) begin
      alu_out_reg    <= alu_result;
      store_data_reg <= fwd_b;
      rw_reg         <= RW_ex;
      mem_en_reg     <= mem_en_ex;
      mem_rw_reg     <= mem_rw_ex;
      reg_wr_reg     <= reg_wr_next;
      zero_reg       <= (alu_result == '0);
      ovf_reg        <= alu_ovf & ~mem_class;
    end
  end

  assign alu_out_mem    = alu_out_reg;
  assign store_data_mem = store_data_reg;
  assign RW_dm          = rw_reg;
  assign mem_en_mem     = mem_en_reg;
  assign mem_rw_mem     = mem_rw_reg;
  assign reg_wr_mem     = reg_wr_reg;
  assign zero_mem       = zero_reg;
  assign ovf_mem        = ovf_reg;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed vectors push hand-computed
// EX/MEM contents; a negedge monitor pops and compares one entry per cycle.
module tb_execute_stage;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] sd;
    logic [4:0]  rw;
    logic        en;
    logic        rwf;
    logic        regwr;
    logic        zero;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, stall, flush, valid_ex;
  logic [5:0]  op_dec;
  logic [15:0] imm;
  logic        imm_sel;
  logic [1:0]  mux_sel_A, mux_sel_B;
  logic [4:0]  RW_ex;
  logic        mem_en_ex, mem_rw_ex;
  logic [31:0] rs_data, rt_data, wb_data;
  logic [31:0] alu_out_mem, store_data_mem;
  logic [4:0]  RW_dm;
  logic        mem_en_mem, mem_rw_mem, reg_wr_mem, zero_mem, ovf_mem;

  int total = 0;
  int bad   = 0;
  int txn   = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  execute_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .valid_ex       (valid_ex),
    .op_dec         (op_dec),
    .imm            (imm),
    .imm_sel        (imm_sel),
    .mux_sel_A      (mux_sel_A),
    .mux_sel_B      (mux_sel_B),
    .RW_ex          (RW_ex),
    .mem_en_ex      (mem_en_ex),
    .mem_rw_ex      (mem_rw_ex),
    .rs_data        (rs_data),
    .rt_data        (rt_data),
    .wb_data        (wb_data),
    .alu_out_mem    (alu_out_mem),
    .store_data_mem (store_data_mem),
    .RW_dm          (RW_dm),
    .mem_en_mem     (mem_en_mem),
    .mem_rw_mem     (mem_rw_mem),
    .reg_wr_mem     (reg_wr_mem),
    .zero_mem       (zero_mem),
    .ovf_mem        (ovf_mem)
  );

  function automatic exp_t mk(logic [31:0] alu, logic [31:0] sd, logic [4:0] rw,
                              logic en, logic rwf, logic regwr, logic zero, logic ovf);
    exp_t e;
    e.alu = alu; e.sd = sd; e.rw = rw; e.en = en;
    e.rwf = rwf; e.regwr = regwr; e.zero = zero; e.ovf = ovf;
    return e;
  endfunction

  // Monitor: the entry pushed before edge N is compared at the negedge after it.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e, a;
      e = q.pop_front();
      a = mk(alu_out_mem, store_data_mem, RW_dm, mem_en_mem, mem_rw_mem,
             reg_wr_mem, zero_mem, ovf_mem);
      total++;
      txn++;
      if (a !== e) begin
        bad++;
        $display("FAIL txn%0d exmem: got alu=%h sd=%h rw=%0d en=%b rwf=%b regwr=%b z=%b ovf=%b, want alu=%h sd=%h rw=%0d en=%b rwf=%b regwr=%b z=%b ovf=%b",
                 txn, a.alu, a.sd, a.rw, a.en, a.rwf, a.regwr, a.zero, a.ovf,
                 e.alu, e.sd, e.rw, e.en, e.rwf, e.regwr, e.zero, e.ovf);
      end else begin
        $display("txn%0d ok alu=%h sd=%h rw=%0d regwr=%b z=%b ovf=%b",
                 txn, a.alu, a.sd, a.rw, a.regwr, a.zero, a.ovf);
      end
    end
  end

  task automatic defaults();
    reset = 1'b0; stall = 1'b0; flush = 1'b0; valid_ex = 1'b1;
    op_dec = 6'd0; imm = 16'd0; imm_sel = 1'b0;
    mux_sel_A = 2'b00; mux_sel_B = 2'b00; RW_ex = 5'd0;
    mem_en_ex = 1'b0; mem_rw_ex = 1'b0;
    rs_data = 32'd0; rt_data = 32'd0; wb_data = 32'd0;
  endtask

  task automatic alu_op(logic [5:0] op, logic [31:0] rs, logic [31:0] rt, logic [4:0] rw);
    defaults();
    op_dec = op; rs_data = rs; rt_data = rt; RW_ex = rw;
  endtask

  // Push the expectation for the current inputs and advance one cycle.
  task automatic cyc(exp_t e);
    q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  localparam exp_t ZERO = '0;

  initial begin
    defaults();
    @(negedge clk);
    #1;

    // Reset with random inputs, including random stall/flush.
    for (int i = 0; i < 2; i++) begin
      reset = 1'b1; stall = 1'($urandom); flush = 1'($urandom); valid_ex = 1'b1;
      op_dec = 6'($urandom); imm = 16'($urandom); imm_sel = 1'($urandom);
      mux_sel_A = 2'($urandom); mux_sel_B = 2'($urandom); RW_ex = 5'($urandom);
      mem_en_ex = 1'($urandom); mem_rw_ex = 1'($urandom);
      rs_data = $urandom; rt_data = $urandom; wb_data = $urandom;
      cyc(ZERO);
    end

    alu_op(6'd0, 32'd5, 32'd7, 5'd3);
    cyc(mk(32'd12, 32'd7, 5'd3, 0, 0, 1, 0, 0));
    alu_op(6'd1, 32'd7, 32'd7, 5'd4);
    cyc(mk(32'd0, 32'd7, 5'd4, 0, 0, 1, 1, 0));

    // Forwarding chain
    alu_op(6'd0, 32'd5, 32'd7, 5'd3);
    cyc(mk(32'd12, 32'd7, 5'd3, 0, 0, 1, 0, 0));
    alu_op(6'd4, 32'h999, 32'hF, 5'd5); mux_sel_A = 2'b01;
    cyc(mk(32'h3, 32'hF, 5'd5, 0, 0, 1, 0, 0));
    alu_op(6'd10, 32'h1, 32'h55, 5'd6); mux_sel_B = 2'b10; wb_data = 32'hAA;
    cyc(mk(32'hAA, 32'hAA, 5'd6, 0, 0, 1, 0, 0));

    // Load and store address generation
    alu_op(6'b010100, 32'h100, 32'h1234, 5'd7); imm = 16'hFFFC; mem_en_ex = 1'b1;
    cyc(mk(32'hFC, 32'h1234, 5'd7, 1, 0, 1, 0, 0));
    alu_op(6'b010101, 32'h200, 32'hDEAD, 5'd8); imm = 16'h0008;
    mem_en_ex = 1'b1; mem_rw_ex = 1'b1;
    cyc(mk(32'h208, 32'hDEAD, 5'd8, 1, 1, 0, 0, 0));

    // Overflow and signed/shift corner cases
    alu_op(6'd0, 32'h7FFFFFFF, 32'd1, 5'd9);
    cyc(mk(32'h80000000, 32'd1, 5'd9, 0, 0, 1, 0, 1));
    alu_op(6'd1, 32'h80000000, 32'd1, 5'd9);
    cyc(mk(32'h7FFFFFFF, 32'd1, 5'd9, 0, 0, 1, 0, 1));
    alu_op(6'd6, 32'hFFFFFFFF, 32'd1, 5'd10);
    cyc(mk(32'd1, 32'd1, 5'd10, 0, 0, 1, 0, 0));
    alu_op(6'd2, 32'hF0F0, 32'hFF00, 5'd12);
    cyc(mk(32'hF000, 32'hFF00, 5'd12, 0, 0, 1, 0, 0));
    alu_op(6'd5, 32'd0, 32'd0, 5'd13);
    cyc(mk(32'hFFFFFFFF, 32'd0, 5'd13, 0, 0, 1, 0, 0));
    alu_op(6'd7, 32'h1, 32'h0, 5'd14); imm_sel = 1'b1; imm = 16'd31;
    cyc(mk(32'h80000000, 32'd0, 5'd14, 0, 0, 1, 0, 0));
    alu_op(6'd9, 32'h80000000, 32'd4, 5'd11);
    cyc(mk(32'hF8000000, 32'd4, 5'd11, 0, 0, 1, 0, 0));

    // Stall for three cycles while inputs change: contents frozen.
    for (int i = 0; i < 3; i++) begin
      alu_op(6'd0, 32'(i + 1), 32'd1, 5'd20); stall = 1'b1;
      cyc(mk(32'hF8000000, 32'd4, 5'd11, 0, 0, 1, 0, 0));
    end
    alu_op(6'd0, 32'd1, 32'd1, 5'd20); stall = 1'b1; flush = 1'b1;
    cyc(ZERO);

    alu_op(6'd0, 32'd2, 32'd3, 5'd0);
    cyc(mk(32'd5, 32'd3, 5'd0, 0, 0, 0, 0, 0));
    alu_op(6'd0, 32'd2, 32'd3, 5'd2); valid_ex = 1'b0;
    cyc(ZERO);
    alu_op(6'd0, 32'd2, 32'd3, 5'd2); flush = 1'b1;
    cyc(ZERO);

    // Held EX/MEM value remains the 01 source across a stall.
    alu_op(6'd0, 32'd10, 32'd20, 5'd1);
    cyc(mk(32'd30, 32'd20, 5'd1, 0, 0, 1, 0, 0));
    alu_op(6'd0, 32'd0, 32'd1, 5'd2); mux_sel_A = 2'b01; stall = 1'b1;
    cyc(mk(32'd30, 32'd20, 5'd1, 0, 0, 1, 0, 0));
    alu_op(6'd0, 32'd0, 32'd1, 5'd2); mux_sel_A = 2'b01;
    cyc(mk(32'd31, 32'd1, 5'd2, 0, 0, 1, 0, 0));
    alu_op(6'd8, 32'd0, 32'd4, 5'd3); mux_sel_A = 2'b01;
    cyc(mk(32'd1, 32'd4, 5'd3, 0, 0, 1, 0, 0));

    defaults();
    @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
